// File: rtl/adder_result_stage_pkg.sv
// Shared ALU definitions: condition-flag layout and the default datapath width.
package adder_result_stage_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FLAGS_W = 4;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef logic [FLAGS_W-1:0] flags_t;

endpackage

// File: rtl/sync_fifo.sv
// In-order synchronous FIFO with a valid/ready handshake on both sides.
// The head entry is held in its own register so the outputs are fully registered.
module sync_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] head_r;

    logic             push_s;
    logic             pop_s;
    logic [PW-1:0]    rd_ptr_nxt_s;
    logic [CW-1:0]    count_nxt_s;
    logic [WIDTH-1:0] head_nxt_s;

    assign in_ready  = (count_r != CW'(DEPTH));
    assign out_valid = (count_r != {CW{1'b0}});
    assign out_data  = head_r;
    assign count     = count_r;

    // Handshake decode, next occupancy, and the entry that becomes head after this edge.
    always_comb begin
        push_s       = in_valid && in_ready;
        pop_s        = out_valid && out_ready;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        head_nxt_s   = head_r;
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
        // The entry being written becomes head only when nothing older remains.
        if (count_nxt_s == {CW{1'b0}}) begin
            head_nxt_s = head_r;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = in_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Entry storage: cleared on reset so no stale data can surface later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer, occupancy and head registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            head_r   <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_r <= push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            head_r   <= head_nxt_s;
        end
    end

endmodule

// File: rtl/adder_result_stage.sv
// Registered result stage behind the ALU adder: derives N/Z/C/V at capture time
// and buffers {sum, flags} so writeback can stall without losing results.
module adder_result_stage
    import adder_result_stage_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_sum,
    input  logic                     in_cout,
    input  logic                     in_a_msb,
    input  logic                     in_b_msb,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [FLAGS_W-1:0]       out_flags,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int unsigned EW = WIDTH + FLAGS_W;

    flags_t           flags_s;
    logic [EW-1:0]    wr_entry_s;
    logic [EW-1:0]    rd_entry_s;

    // Condition flags from the raw adder outputs; V is signed overflow of the add.
    always_comb begin
        flags_s         = {FLAGS_W{1'b0}};
        flags_s[FLAG_N] = in_sum[WIDTH-1];
        flags_s[FLAG_Z] = (in_sum == {WIDTH{1'b0}});
        flags_s[FLAG_C] = in_cout;
        flags_s[FLAG_V] = (in_a_msb == in_b_msb) && (in_sum[WIDTH-1] != in_a_msb);
    end

    assign wr_entry_s = {in_sum, flags_s};
    assign out_result = rd_entry_s[EW-1:FLAGS_W];
    assign out_flags  = rd_entry_s[FLAGS_W-1:0];

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (wr_entry_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (rd_entry_s),
        .count     (out_count)
    );

endmodule
